// File: rtl/display_pixel_writer.sv
// Avalon-MM slave that queues CPU pixel writes, tagged with an auto-incrementing
// address, toward the display-buffer RAM write port through a small FIFO.
module display_pixel_writer #(
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              irq
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned ENT_W = ADDR_W + DATA_W;

    localparam logic [2:0] REG_DATA    = 3'd0;
    localparam logic [2:0] REG_ADDR    = 3'd1;
    localparam logic [2:0] REG_LIMIT   = 3'd2;
    localparam logic [2:0] REG_STATUS  = 3'd3;
    localparam logic [2:0] REG_CONTROL = 3'd4;

    logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] limit_q, limit_d;
    logic [DATA_W-1:0] last_data_q, last_data_d;
    logic              ovf_q, ovf_d;
    logic              drain_en_q, drain_en_d;
    logic              irq_en_q, irq_en_d;

    logic wr_en, empty, full, push, pop, flush;
    logic unused_wdata;

    assign unused_wdata = ^writedata;
    assign wr_en = chipselect & ~write_n;
    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_W'(FIFO_DEPTH));
    // A push while full is dropped even if the display pops in the same cycle.
    assign push  = wr_en && (address == REG_DATA) && !full;
    assign flush = wr_en && (address == REG_CONTROL) && writedata[31];
    assign pop   = pix_valid & pix_ready;

    assign pix_valid = drain_en_q & ~empty;
    assign {pix_addr, pix_data} = mem_q[rd_ptr_q];
    assign irq = irq_en_q & (empty | ovf_q);

    // Register-file and FIFO-control next state.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        addr_d      = addr_q;
        limit_d     = limit_q;
        last_data_d = last_data_q;
        ovf_d       = ovf_q;
        drain_en_d  = drain_en_q;
        irq_en_d    = irq_en_q;

        if (wr_en) begin
            case (address)
                REG_DATA: begin
                    last_data_d = writedata[DATA_W-1:0];
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        addr_d = (addr_q == limit_q) ? '0 : addr_q + ADDR_W'(1);
                    end
                end
                REG_ADDR:    addr_d  = writedata[ADDR_W-1:0];
                REG_LIMIT:   limit_d = writedata[ADDR_W-1:0];
                REG_STATUS:  if (writedata[2]) ovf_d = 1'b0;
                REG_CONTROL: begin
                    drain_en_d = writedata[0];
                    irq_en_d   = writedata[1];
                end
                default: ;
            endcase
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      level_d = level_q + LVL_W'(1);
            else if (pop && !push) level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            addr_q      <= '0;
            limit_q     <= '1;
            last_data_q <= '0;
            ovf_q       <= 1'b0;
            drain_en_q  <= 1'b0;
            irq_en_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            addr_q      <= addr_d;
            limit_q     <= limit_d;
            last_data_q <= last_data_d;
            ovf_q       <= ovf_d;
            drain_en_q  <= drain_en_d;
            irq_en_q    <= irq_en_d;
        end
    end

    // Entry storage needs no reset: validity is tracked by level and pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {addr_q, writedata[DATA_W-1:0]};
    end

    always_comb begin
        readdata = '0;
        case (address)
            REG_DATA:    readdata = 32'(last_data_q);
            REG_ADDR:    readdata = 32'(addr_q);
            REG_LIMIT:   readdata = 32'(limit_q);
            REG_STATUS: begin
                readdata[0]          = empty;
                readdata[1]          = full;
                readdata[2]          = ovf_q;
                readdata[8 +: LVL_W] = level_q;
            end
            REG_CONTROL: readdata = {30'd0, irq_en_q, drain_en_q};
            default:     readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_display_pixel_writer.sv
// Directed bench for display_pixel_writer: register map, FIFO ordering,
// overflow, back-pressure, flush and interrupt behaviour.
module tb_display_pixel_writer;

    localparam int unsigned DW = 24;
    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [AW-1:0] pix_addr;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          pix_ready;
    logic          irq;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_wr_cyc = 0;
    bit bp_en = 1'b0;

    logic [AW+DW-1:0] got_q[$];
    int               got_cyc[$];

    display_pixel_writer #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .pix_addr(pix_addr), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    // Display-side monitor: records every completed handshake and its cycle.
    always @(posedge clk) begin
        if (reset_n && pix_valid && pix_ready) begin
            got_q.push_back({pix_addr, pix_data});
            got_cyc.push_back(cyc);
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (bp_en) pix_ready = 1'($urandom_range(0, 1));
    end

    task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1;
        last_wr_cyc = cyc - 1;
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
        d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (pix_valid !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b irq=%b, required 0 0", pix_valid, irq);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        cpu_read(3'd3, rd);
        checks++;
        if (rd !== 32'h0000_0001) begin errors++; $display("FAIL reset_status: got %h, required 00000001", rd); end
        cpu_read(3'd1, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h, required 0", rd); end
        cpu_read(3'd2, rd);
        checks++;
        if (rd !== 32'h3FF) begin errors++; $display("FAIL reset_limit: got %h, required 3ff", rd); end
        cpu_read(3'd0, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_data: got %h, required 0", rd); end
        cpu_read(3'd4, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_control: got %h, required 0", rd); end
        cpu_read(3'd6, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_unmapped: got %h, required 0", rd); end
    endtask

    task automatic test_wrap;
        logic [31:0]      rd;
        int               wc[3];
        logic [AW+DW-1:0] exp[3];
        exp[0] = {10'd2, 24'hAA0001};
        exp[1] = {10'd3, 24'hAA0002};
        exp[2] = {10'd0, 24'hAA0003};
        pix_ready = 1'b1;
        cpu_write(3'd2, 32'd3);
        cpu_write(3'd1, 32'd2);
        cpu_write(3'd4, 32'd1);
        got_q.delete(); got_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            cpu_write(3'd0, 32'hAA0001 + 32'(i));
            wc[i] = last_wr_cyc;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != 3) begin
            errors++;
            $display("FAIL wrap_count: got %0d pops, required 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_q[i] !== exp[i] || got_cyc[i] != wc[i] + 1) begin
                    errors++;
                    $display("FAIL wrap_pix%0d: got %h@%0d, required %h@%0d",
                             i, got_q[i], got_cyc[i], exp[i], wc[i] + 1);
                end
            end
        end
        cpu_read(3'd1, rd);
        checks++;
        if (rd !== 32'd1) begin errors++; $display("FAIL wrap_addr_end: got %h, required 1", rd); end
        cpu_read(3'd0, rd);
        checks++;
        if (rd !== 32'hAA0003) begin errors++; $display("FAIL wrap_last_data: got %h, required aa0003", rd); end
    endtask

    task automatic test_overflow;
        logic [31:0] rd;
        cpu_write(3'd4, 32'd0);
        cpu_write(3'd2, 32'h3FF);
        cpu_write(3'd1, 32'h10);
        for (int i = 0; i < 9; i++) cpu_write(3'd0, 32'hB0 + 32'(i));
        cpu_read(3'd3, rd);
        checks++;
        if (rd !== 32'h0000_0806) begin errors++; $display("FAIL ovf_status: got %h, required 00000806", rd); end
        cpu_read(3'd1, rd);
        checks++;
        if (rd !== 32'h18) begin errors++; $display("FAIL ovf_addr: got %h, required 18", rd); end
        cpu_read(3'd0, rd);
        checks++;
        if (rd !== 32'hB8) begin errors++; $display("FAIL ovf_last_data: got %h, required b8", rd); end
        cpu_write(3'd3, 32'h4);
        cpu_read(3'd3, rd);
        checks++;
        if (rd !== 32'h0000_0802) begin errors++; $display("FAIL ovf_clear: got %h, required 00000802", rd); end
        got_q.delete(); got_cyc.delete();
        pix_ready = 1'b1;
        cpu_write(3'd4, 32'd1);
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != 8) begin
            errors++;
            $display("FAIL ovf_drain_count: got %0d pops, required 8", got_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_q[i] !== {10'(16 + i), 24'(32'hB0 + 32'(i))}) begin
                    errors++;
                    $display("FAIL ovf_drain%0d: got %h, required %h",
                             i, got_q[i], {10'(16 + i), 24'(32'hB0 + 32'(i))});
                end
            end
        end
        cpu_read(3'd3, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL ovf_drained_status: got %h, required 1", rd); end
    endtask

    task automatic test_back_to_back;
        logic [31:0]      rd;
        logic [AW+DW-1:0] exp[$];
        bit               done;
        cpu_write(3'd1, 32'h20);
        got_q.delete(); got_cyc.delete();
        bp_en = 1'b1;
        for (int b = 0; b < 4; b++) begin
            done = 1'b0;
            for (int t = 0; t < 100 && !done; t++) begin
                cpu_read(3'd3, rd);
                if (rd[15:8] <= 8'd3) done = 1'b1;
            end
            checks++;
            if (!done) begin errors++; $display("FAIL bp_wait%0d: level %0d, required <=3", b, rd[15:8]); end
            for (int i = 0; i < 5; i++) begin
                int n;
                n = b * 5 + i;
                cpu_write(3'd0, 32'hC00000 + 32'(n * 32'h111));
                exp.push_back({10'(32 + n), 24'(32'hC00000 + 32'(n * 32'h111))});
            end
            cpu_read(3'd3, rd);
            checks++;
            if (rd[15:8] > 8'd8 || rd[2] !== 1'b0) begin
                errors++;
                $display("FAIL bp_level%0d: level %0d ovf %b, required <=8 and 0", b, rd[15:8], rd[2]);
            end
        end
        done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            cpu_read(3'd3, rd);
            if (rd[0]) done = 1'b1;
        end
        bp_en = 1'b0;
        @(negedge clk);
        pix_ready = 1'b0;
        checks++;
        if (!done) begin errors++; $display("FAIL bp_drain: status %h, required empty", rd); end
        checks++;
        if (got_q.size() != 20) begin
            errors++;
            $display("FAIL bp_count: got %0d pops, required 20", got_q.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                checks++;
                if (got_q[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL bp_pix%0d: got %h, required %h", i, got_q[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_flush;
        logic [31:0] rd;
        pix_ready = 1'b0;
        for (int i = 0; i < 5; i++) cpu_write(3'd0, 32'hD0 + 32'(i));
        cpu_read(3'd3, rd);
        checks++;
        if (rd !== 32'h0000_0500) begin errors++; $display("FAIL flush_fill: got %h, required 00000500", rd); end
        // Flush write lands on the same edge as a pop.
        @(negedge clk);
        pix_ready = 1'b1; address = 3'd4; writedata = 32'h8000_0001;
        chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1; pix_ready = 1'b0;
        checks++;
        if (pix_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b, required 0", pix_valid); end
        cpu_read(3'd3, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL flush_status: got %h, required 00000001", rd); end
        cpu_read(3'd4, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL flush_control: got %h, required 00000001", rd); end
        for (int i = 0; i < 3; i++) cpu_write(3'd0, 32'hE0 + 32'(i));
        cpu_read(3'd3, rd);
        checks++;
        if (rd !== 32'h0000_0300) begin errors++; $display("FAIL pushpop_pre: got %h, required 00000300", rd); end
        @(negedge clk);
        pix_ready = 1'b1; address = 3'd0; writedata = 32'hE3;
        chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1; pix_ready = 1'b0;
        cpu_read(3'd3, rd);
        checks++;
        if (rd !== 32'h0000_0300) begin errors++; $display("FAIL pushpop_level: got %h, required 00000300", rd); end
        pix_ready = 1'b1;
        repeat (5) @(posedge clk);
        pix_ready = 1'b0;
        cpu_read(3'd3, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL pushpop_drain: got %h, required 00000001", rd); end
    endtask

    task automatic test_irq;
        logic [31:0] rd;
        cpu_write(3'd4, 32'd2);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_empty: got %b, required 1", irq); end
        cpu_write(3'd0, 32'hF0);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_push: got %b, required 0", irq); end
        for (int i = 1; i < 9; i++) cpu_write(3'd0, 32'hF0 + 32'(i));
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_overflow: got %b, required 1", irq); end
        pix_ready = 1'b1;
        cpu_write(3'd4, 32'd3);
        @(negedge clk);
        #2;
        checks++;
        if (pix_valid !== 1'b1 || irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_middrain: valid=%b irq=%b, required 1 1", pix_valid, irq);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (pix_valid !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_async_reset: valid=%b irq=%b, required 0 0", pix_valid, irq);
        end
        @(negedge clk);
        reset_n = 1'b1;
        pix_ready = 1'b0;
        cpu_read(3'd3, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL irq_post_reset: got %h, required 00000001", rd); end
    endtask

    initial begin
        address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        pix_ready = 1'b0;
        test_reset();
        test_wrap();
        test_overflow();
        test_back_to_back();
        test_flush();
        test_irq();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_pixel_writer.md
# display_pixel_writer

Parametrised Avalon-MM slave that takes pixel writes from the Nios II and queues them, with auto-incrementing pixel addresses, to the display-buffer RAM write port of the LED tile. It extends the single 24-bit display data output port with these features:
- configurable pixel and address widths
- a FIFO that decouples CPU writes from display-side back-pressure
- address wrap, status and flush
- an interrupt

One clock domain.

## Interface
Parameters:
- DATA_W, 24, pixel data width (1..32)
- ADDR_W, 10, pixel address width (1..16)
- FIFO_DEPTH, 8, entries; must be a power of two, at least 2
- LVL_W, $clog2(FIFO_DEPTH+1), derived width of the level count

Ports:
- clk  in  1  system clock; all logic on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  Avalon register index
- chipselect  in  1  Avalon select
- write_n  in  1  Avalon write strobe, active low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data; combinational, zero read latency
- pix_addr  out  ADDR_W  display RAM address of the FIFO head entry
- pix_data  out  DATA_W  display RAM data of the FIFO head entry
- pix_valid  out  1  head entry is offered to the display RAM
- pix_ready  in  1  display RAM accepts the offered entry
- irq  out  1  level interrupt

## Operation
Register map. A write occurs when chipselect is high and write_n is low.
- 0 DATA
  - Write: push {ADDR, writedata[DATA_W-1:0]} into the FIFO and store the data in LAST_DATA.
  - Read: LAST_DATA, zero-extended.
- 1 ADDR (R/W): the next pixel address.
  - Reset value: 0.
  - After an accepted push: if ADDR==LIMIT, ADDR becomes 0; otherwise ADDR becomes ADDR+1.
  - Writing register 1 loads writedata[ADDR_W-1:0].
- 2 LIMIT (R/W): wrap point. Reset value: all ones.
- 3 STATUS
  - Read: bit0 empty, bit1 full, bit2 overflow (sticky), bits[8+LVL_W-1:8] level.
  - Write: a 1 in bit2 clears overflow. Other bits are ignored.
- 4 CONTROL (R/W): bit0 drain_en, bit1 irq_en. Both reset to 0.
  - Writing 1 to bit31 flushes the FIFO.
  - Bit31 is self-clearing and always reads 0.
- Addresses 5-7: reads return 0; writes are ignored.

FIFO:
- Entries are ADDR_W+DATA_W wide and held in a register array.
- Read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- level counts 0..FIFO_DEPTH.
- A push is accepted only if the FIFO is not full at the clock edge. A push while full is dropped, even if a pop happens in the same cycle. A dropped push:
  - sets overflow;
  - leaves ADDR unchanged;
  - still updates LAST_DATA.
- Pop happens when pix_valid and pix_ready are both high.
- Simultaneous accepted push and pop leaves level unchanged.
- Flush:
  - sets both pointers and level to 0;
  - takes precedence over a push or pop in the same cycle;
  - does not change ADDR, LIMIT or overflow.

Display side:
- pix_valid = drain_en & !empty.
- pix_addr and pix_data are the head entry, driven combinationally from the array.
- Clearing drain_en holds entries in the FIFO and drops nothing.

Interrupt:
- irq = irq_en & (empty | overflow).
- irq is level-sensitive. Clear it by pushing data, writing 1 to STATUS bit2, or clearing irq_en.

Reset values (reset_n low, asynchronous):
- FIFO empty, level 0.
- ADDR = 0, LIMIT = all ones.
- LAST_DATA, overflow, drain_en and irq_en all 0.
- Therefore pix_valid = 0 and irq = 0.
- readdata follows the reset register values.

## Timing
- Register writes take effect at the clock edge of the write cycle.
- An entry pushed at edge N is on pix_addr/pix_data with pix_valid high from edge N into cycle N+1, provided drain_en is set.
- Pop at edge M: the next entry (or pix_valid low) is presented after edge M.
- Sustained throughput is one pixel per clock when pix_ready is held high and the CPU writes every cycle.
- STATUS and level reflect the state after the most recent edge; there is no additional lag.
- If reset asserts mid-stream, queued entries are discarded immediately and no partial handshake is completed.

## Test plan
- Reset, then read all registers. Required values:
  - STATUS = 0x0000_0001
  - ADDR = 0
  - LIMIT = 0x3FF
  - pix_valid = 0, irq = 0
- Auto-increment and wrap:
  1. Set LIMIT=3, ADDR=2 and drain_en=1, with pix_ready held high.
  2. Write DATA 0xAA0001, 0xAA0002, 0xAA0003.
  3. Required: the display side sees (2,0xAA0001), (3,0xAA0002), (0,0xAA0003), each accepted one cycle after its write. ADDR reads 1 at the end.
- Overflow and hold:
  1. Set drain_en=0 and push 9 words (FIFO_DEPTH=8).
  2. Required: STATUS shows full=1, level=8, overflow=1, and ADDR advanced by 8.
  3. Write 0x4 to STATUS. Required: overflow clears.
  4. Set drain_en=1. Required: exactly 8 entries drain in order.
- Back-pressure: pix_ready toggles pseudo-randomly while 20 pixels are written in bursts. Required: every address/data pair is delivered exactly once, in order, and level never exceeds 8.
- Flush and simultaneous events:
  1. Fill to level 5, then write CONTROL bit31 in the same cycle as a pop.
  2. Required: level becomes 0 and pix_valid drops the next cycle.
  3. Required: a push and pop in the same cycle at level 3 leaves level at 3.
- Interrupt:
  1. Set irq_en=1 with the FIFO empty. Required: irq=1.
  2. Push with drain_en=0. Required: irq=0.
  3. Overflow the FIFO. Required: irq=1.
  4. Assert reset_n low mid-drain. Required: pix_valid and irq drop immediately, asynchronously.
